// File: rtl/clk_div_pkg.sv
// Shared types and constants for the clock-enable divider bank.
package clk_div_pkg;
    localparam int CNT_W_DEF = 12;
    localparam int SCLK_DIV  = 255;
    localparam int DCLK_DIV  = 2047;

    typedef enum logic {
        TOGGLE = 1'b0,
        PULSE  = 1'b1
    } div_mode_t;
endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: up-counter, active/pending divisor+mode, registered out/tick.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int               CNT_W   = CNT_W_DEF,
    parameter logic [CNT_W-1:0] RST_DIV = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    input  div_mode_t        wr_mode,
    output logic             out,
    output logic             tick,
    output logic             upd_pend
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] pdiv_q, pdiv_d;
    div_mode_t        mode_q, mode_d;
    div_mode_t        pmode_q, pmode_d;
    logic             pend_q, pend_d;
    logic             out_q, out_d;
    logic             tick_q, tick_d;

    logic             terminal;
    logic             apply;
    logic [CNT_W-1:0] eff_div;
    div_mode_t        eff_mode;

    always_comb begin
        terminal = (cnt_q >= div_q);
        apply    = sync || !en || terminal;
        // A write coinciding with a boundary wins over an older pending value.
        eff_div  = wr ? wr_div  : (pend_q ? pdiv_q  : div_q);
        eff_mode = wr ? wr_mode : (pend_q ? pmode_q : mode_q);

        cnt_d   = cnt_q + 1'b1;
        out_d   = out_q;
        tick_d  = 1'b0;
        div_d   = div_q;
        mode_d  = mode_q;
        pdiv_d  = pdiv_q;
        pmode_d = pmode_q;
        pend_d  = pend_q;

        if (apply) begin
            div_d  = eff_div;
            mode_d = eff_mode;
            pend_d = 1'b0;
        end else if (wr) begin
            pdiv_d  = wr_div;
            pmode_d = wr_mode;
            pend_d  = 1'b1;
        end

        if (sync || !en) begin
            cnt_d = '0;
            out_d = 1'b0;
        end else if (terminal) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            out_d  = (eff_mode == PULSE) ? 1'b1 : ~out_q;
        end else if (mode_q == PULSE) begin
            out_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            div_q   <= RST_DIV;
            mode_q  <= TOGGLE;
            pdiv_q  <= '0;
            pmode_q <= TOGGLE;
            pend_q  <= 1'b0;
            out_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            mode_q  <= mode_d;
            pdiv_q  <= pdiv_d;
            pmode_q <= pmode_d;
            pend_q  <= pend_d;
            out_q   <= out_d;
            tick_q  <= tick_d;
        end
    end

    assign out      = out_q;
    assign tick     = tick_q;
    assign upd_pend = pend_q;
endmodule

// File: rtl/clk_div_bank.sv
// Bank of independent divider channels sharing one write port and a global sync.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int                        CHANNELS    = 2,
    parameter int                        CNT_W       = CNT_W_DEF,
    parameter logic [CHANNELS*CNT_W-1:0] DEFAULT_DIV = {CNT_W'(DCLK_DIV), CNT_W'(SCLK_DIV)}
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] en,
    input  logic                sync,
    input  logic                wr_en,
    input  logic [2:0]          wr_ch,
    input  logic [CNT_W-1:0]    wr_div,
    input  logic                wr_mode,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] upd_pend
);
    logic [CHANNELS-1:0] wr_sel;

    // Out-of-range channel indices match no channel and are dropped.
    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            wr_sel[i] = wr_en && (int'(wr_ch) == i);
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        clk_div_chan #(
            .CNT_W   (CNT_W),
            .RST_DIV (DEFAULT_DIV[i*CNT_W +: CNT_W])
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .en       (en[i]),
            .sync     (sync),
            .wr       (wr_sel[i]),
            .wr_div   (wr_div),
            .wr_mode  (div_mode_t'(wr_mode)),
            .out      (out[i]),
            .tick     (tick[i]),
            .upd_pend (upd_pend[i])
        );
    end
endmodule

// File: tb/tb_clk_div_bank.sv
// Bench for clk_div_bank: directed scenarios plus random traffic against a countdown reference model.
module tb_clk_div_bank;
    logic        clk;
    logic        rst;
    logic [1:0]  en;
    logic        sync;
    logic        wr_en;
    logic [2:0]  wr_ch;
    logic [11:0] wr_div;
    logic        wr_mode;
    logic [1:0]  out;
    logic [1:0]  tick;
    logic [1:0]  upd_pend;

    int checks   = 0;
    int failures = 0;

    // Reference model: cycles left until the next tick, plus waveform/pending state.
    int m_div   [2];
    int m_pdiv  [2];
    int m_left  [2];
    bit m_mode  [2];
    bit m_pmode [2];
    bit m_pend  [2];
    bit m_out   [2];
    bit m_tick  [2];

    clk_div_bank dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sync     (sync),
        .wr_en    (wr_en),
        .wr_ch    (wr_ch),
        .wr_div   (wr_div),
        .wr_mode  (wr_mode),
        .out      (out),
        .tick     (tick),
        .upd_pend (upd_pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_div[0] = 255;
        m_div[1] = 2047;
        for (int ch = 0; ch < 2; ch++) begin
            m_mode[ch] = 1'b0;
            m_pend[ch] = 1'b0;
            m_out[ch]  = 1'b0;
            m_tick[ch] = 1'b0;
            m_left[ch] = m_div[ch] + 1;
        end
    endtask

    task automatic model_edge();
        for (int ch = 0; ch < 2; ch++) begin
            bit wr, restart, boundary;
            wr       = wr_en && (int'(wr_ch) == ch);
            restart  = sync || !en[ch];
            boundary = restart || (m_left[ch] == 1);
            if (boundary) begin
                if (wr) begin
                    m_div[ch]  = int'(wr_div);
                    m_mode[ch] = wr_mode;
                end else if (m_pend[ch]) begin
                    m_div[ch]  = m_pdiv[ch];
                    m_mode[ch] = m_pmode[ch];
                end
                m_pend[ch] = 1'b0;
            end else if (wr) begin
                m_pdiv[ch]  = int'(wr_div);
                m_pmode[ch] = wr_mode;
                m_pend[ch]  = 1'b1;
            end
            if (restart) begin
                m_out[ch]  = 1'b0;
                m_tick[ch] = 1'b0;
                m_left[ch] = m_div[ch] + 1;
            end else if (m_left[ch] == 1) begin
                m_tick[ch] = 1'b1;
                m_out[ch]  = m_mode[ch] ? 1'b1 : ~m_out[ch];
                m_left[ch] = m_div[ch] + 1;
            end else begin
                m_tick[ch] = 1'b0;
                m_left[ch] = m_left[ch] - 1;
                if (m_mode[ch]) m_out[ch] = 1'b0;
            end
        end
    endtask

    task automatic step();
        logic [1:0] e_out, e_tick, e_pend;
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        #1;
        for (int ch = 0; ch < 2; ch++) begin
            e_out[ch]  = m_out[ch];
            e_tick[ch] = m_tick[ch];
            e_pend[ch] = m_pend[ch];
        end
        chk("model_out", out, e_out);
        chk("model_tick", tick, e_tick);
        chk("model_upd_pend", upd_pend, e_pend);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int nt;
        rst     = 1'b1;
        en      = 2'b11;
        sync    = 1'b0;
        wr_en   = 1'b0;
        wr_ch   = 3'd0;
        wr_div  = 12'd0;
        wr_mode = 1'b0;
        model_reset();
        #1;
        chk("rst_out", out, 2'b00);
        chk("rst_tick", tick, 2'b00);
        chk("rst_pend", upd_pend, 2'b00);
        do_reset();

        // Default divisors after reset.
        for (int c = 1; c <= 4200; c++) begin
            step();
            if (c == 255)  chk("ch0_no_tick_255", tick[0], 1'b0);
            if (c == 256)  chk("ch0_tick_256", tick[0], 1'b1);
            if (c == 512)  chk("ch0_tick_512", tick[0], 1'b1);
            if (c == 300)  chk("ch0_out_high", out[0], 1'b1);
            if (c == 600)  chk("ch0_out_low", out[0], 1'b0);
            if (c == 2048) chk("ch1_tick_2048", tick[1], 1'b1);
            if (c == 4096) chk("ch1_tick_4096", tick[1], 1'b1);
        end

        // Write ch0 div=3 at cnt=100: held pending until the 256 boundary.
        do_reset();
        for (int c = 1; c <= 100; c++) step();
        wr_en = 1'b1; wr_ch = 3'd0; wr_div = 12'd3; wr_mode = 1'b0;
        for (int c = 101; c <= 270; c++) begin
            step();
            wr_en = 1'b0;
            if (c == 200) chk("pend_held", upd_pend[0], 1'b1);
            if (c == 256) chk("pend_clear_256", upd_pend[0], 1'b0);
            if (c == 256) chk("tick_256", tick[0], 1'b1);
            if (c == 258) chk("no_short_258", tick[0], 1'b0);
            if (c == 260) chk("tick_260", tick[0], 1'b1);
            if (c == 264) chk("tick_264", tick[0], 1'b1);
        end

        // ch0 div=0 toggle: tick constantly high.
        wr_en = 1'b1; wr_ch = 3'd0; wr_div = 12'd0; wr_mode = 1'b0;
        step();
        wr_en = 1'b0;
        for (int c = 0; c < 6; c++) step();
        for (int c = 0; c < 8; c++) begin
            step();
            chk("div0_tick", tick[0], 1'b1);
        end

        // ch1 div=4 pulse.
        wr_en = 1'b1; wr_ch = 3'd1; wr_div = 12'd4; wr_mode = 1'b1;
        step();
        wr_en = 1'b0;
        for (int c = 0; c < 2100 && upd_pend[1]; c++) step();
        chk("ch1_pend_applied", upd_pend[1], 1'b0);
        nt = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            chk("pulse_out_eq_tick", out[1], tick[1]);
            if (tick[1]) nt++;
        end
        chk("pulse_count_20", 2'(nt), 2'(4 % 4));
        checks++;
        assert (nt === 4) else begin
            failures++;
            $error("FAIL pulse_ticks observed=%0d expected=4", nt);
        end

        // Out-of-range channel write is dropped.
        wr_en = 1'b1; wr_ch = 3'd5; wr_div = 12'd9; wr_mode = 1'b1;
        step();
        wr_en = 1'b0;
        chk("bad_ch_no_pend", upd_pend, 2'b00);
        for (int c = 0; c < 12; c++) step();

        // Both channels div=3, skew phases, then sync.
        wr_en = 1'b1; wr_ch = 3'd0; wr_div = 12'd3; wr_mode = 1'b0;
        step();
        wr_ch = 3'd1;
        step();
        wr_en = 1'b0;
        for (int c = 0; c < 10; c++) step();
        en = 2'b01;
        step();
        en = 2'b11;
        step();
        step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        chk("sync_out", out, 2'b00);
        chk("sync_tick", tick, 2'b00);
        for (int c = 1; c <= 12; c++) begin
            step();
            if (c % 4 == 0) chk("sync_aligned_tick", tick, 2'b11);
            else            chk("sync_quiet", tick, 2'b00);
        end
        step(); step(); step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        chk("sync_suppress", tick, 2'b00);

        // Pending write lost on async reset.
        wr_en = 1'b1; wr_ch = 3'd0; wr_div = 12'd7; wr_mode = 1'b1;
        step();
        wr_en = 1'b0;
        chk("pre_rst_pend", upd_pend, 2'b01);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_out", out, 2'b00);
        chk("async_tick", tick, 2'b00);
        chk("async_pend", upd_pend, 2'b00);
        step();
        step();
        rst = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            step();
            if (c == 8)   chk("lost_write_8", tick[0], 1'b0);
            if (c == 256) chk("default_back_256", tick[0], 1'b1);
        end

        // Disable ch0 and re-enable.
        en = 2'b10;
        step();
        chk("dis_out0", out[0], 1'b0);
        for (int c = 0; c < 4; c++) step();
        en = 2'b11;
        for (int c = 1; c <= 256; c++) begin
            step();
            if (c == 255) chk("reen_no_tick", tick[0], 1'b0);
            if (c == 256) chk("reen_tick", tick[0], 1'b1);
        end

        // Random traffic with small divisors.
        wr_en = 1'b1; wr_ch = 3'd1; wr_div = 12'd5; wr_mode = 1'b0;
        sync = 1'b1;
        step();
        for (int c = 0; c < 3000; c++) begin
            en      = ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'b11;
            sync    = ($urandom_range(0, 40) == 0);
            wr_en   = ($urandom_range(0, 5) == 0);
            wr_ch   = 3'($urandom_range(0, 7));
            wr_div  = 12'($urandom_range(0, 9));
            wr_mode = 1'($urandom);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
